// File: rtl/dtop_pkg.sv
// Shared constants, state encoding and parity helper for the scan frame port.
// SCAN_FRAME_PARITY_EN adds one even-parity bit to each frame.
package dtop_pkg;

  localparam int SC_BUS_SIZE    = 37;
  localparam int CNTRL_BUS_SIZE = 8;
  localparam int FRAME_LEN      = SC_BUS_SIZE + CNTRL_BUS_SIZE;

`ifdef SCAN_FRAME_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    APPLY,
    CAPTURE,
    SHIFT_OUT
  } state_t;

  // Bit that makes the zero-padded vector's parity even (frames fit in 64 bits).
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sc_shift_reg.sv
// Right-shifting register: serial in at the MSB, parallel load, parallel out.
// The serial output is q[0]; load takes priority over shift.
module sc_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift_en) begin
      q <= {sin, q[W-1:1]};
    end
  end

endmodule

// File: rtl/scan_frame_port.sv
// Serial <-> parallel port for the scramble datapath (optional parity: SCAN_FRAME_PARITY_EN).
// Latency: last si at edge N -> scin_o/cntrl_o at N+1, scout_i captured and so_vld at N+2.
// Backpressure: si_vld=0 stalls input; so_rdy=0 holds so/so_vld until the sink accepts.
module scan_frame_port
  import dtop_pkg::*;
#(
  parameter int scBusSize    = SC_BUS_SIZE,
  parameter int cntrlBusSize = CNTRL_BUS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    si,
  input  logic                    si_vld,
  output logic [scBusSize-1:0]    scin_o,
  output logic [cntrlBusSize-1:0] cntrl_o,
  input  logic [scBusSize-1:0]    scout_i,
  output logic                    so,
  output logic                    so_vld,
  input  logic                    so_rdy,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int FLEN = cntrlBusSize + scBusSize;
  localparam int ILEN = FLEN + PAR_BITS;
  localparam int OLEN = scBusSize + PAR_BITS;
  localparam int CW   = $clog2(ILEN + 1);
  localparam logic [CW-1:0] ILAST = CW'(ILEN - 1);
  localparam logic [CW-1:0] OLAST = CW'(OLEN - 1);

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [ILEN-1:0] in_q;
  logic [OLEN-1:0] out_q, out_load;
  logic            in_shift, out_shift, out_ld, apply_en;
  logic            in_last, out_last, par_bad, start_acc;

  assign start_acc = (state == IDLE) && start;
  assign in_last   = in_shift && (cnt == ILAST);
  assign out_last  = out_shift && (cnt == OLAST);

`ifdef SCAN_FRAME_PARITY_EN
  // Judged on the final bit as it arrives, so a bad frame never reaches APPLY.
  assign par_bad  = even_par(64'({si, in_q[ILEN-1:1]}));
  assign out_load = {even_par(64'(scout_i)), scout_i};
`else
  assign par_bad  = 1'b0;
  assign out_load = scout_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start) nxt = SHIFT_IN;
      SHIFT_IN:  if (in_last) nxt = par_bad ? IDLE : APPLY;
      APPLY:     nxt = CAPTURE;
      CAPTURE:   nxt = SHIFT_OUT;
      SHIFT_OUT: if (out_last) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    so_vld    = (state == SHIFT_OUT);
    in_shift  = (state == SHIFT_IN) && si_vld;
    apply_en  = (state == APPLY);
    out_ld    = (state == CAPTURE);
    out_shift = (state == SHIFT_OUT) && so_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      scin_o  <= '0;
      cntrl_o <= '0;
      done    <= 1'b0;
    end else begin
      done <= out_last;
      if (start_acc || out_ld) begin
        cnt <= '0;
      end else if (in_shift || out_shift) begin
        cnt <= cnt + CW'(1);
      end
      if (apply_en) begin
        {scin_o, cntrl_o} <= in_q[FLEN-1:0];
      end
    end
  end

`ifdef SCAN_FRAME_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if (in_last && par_bad) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  sc_shift_reg #(.W(ILEN)) u_in_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_dat ({ILEN{1'b0}}),
    .shift_en (in_shift),
    .sin      (si),
    .q        (in_q)
  );

  sc_shift_reg #(.W(OLEN)) u_out_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (out_ld),
    .load_dat (out_load),
    .shift_en (out_shift),
    .sin      (1'b0),
    .q        (out_q)
  );

  assign so = out_q[0];

endmodule
